pin_bus_responder: RTL
======================

# pin_bus_responder

Target-side responder for the asynchronous four-phase pin bus that a host (bench or external MCU) drives through the Tiny Tapeout dedicated inputs. It synchronises the host strobe, decodes read/write commands into a small 8-bit register file with an ID register and a transaction counter, and returns data plus an acknowledge. The host is the initiator; this block is the responder inside the `tt_um_*` top, with `ui_in`/`uio_in`/`uo_out` mapped onto its ports.

## Interface

Parameters:
- `ADDR_W`, 4: address width; register file depth is 2^ADDR_W.
- `ID_VALUE`, 8'hA5: constant returned by address 0.
- `TIMEOUT`, 255: maximum cycles spent in ACK; used only with `RESP_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous reset, active-high.
- `ena`  in  1  design enable; when low, no new transaction starts.
- `strb`  in  1  host strobe, asynchronous to `clk`.
- `we`  in  1  1 = write, 0 = read; stable while `strb` is high.
- `addr`  in  ADDR_W  register address; stable while `strb` is high.
- `wdata`  in  8  write data; stable while `strb` is high.
- `rdata`  out  8  response data, registered.
- `ack`  out  1  acknowledge, registered.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `err`  out  1  sticky error flag.

## Operation

- `strb` passes through a 2-flop synchroniser (`s1`, `s2`) and a delay flop `s3`. Rise = `s2 & ~s3`; fall = `~s2`.
- FSM states: IDLE, EXEC, ACK.
  - IDLE: on rise and `ena`=1, latch `we`/`addr`/`wdata` and go to EXEC. A rise while `ena`=0 is discarded; it is not retried.
  - EXEC: perform access, update `rdata`, increment counter, set `ack`=1, go to ACK.
  - ACK: hold `ack`=1 and `rdata`. On `s2`=0, clear `ack` and go to IDLE.
- Register map:
  - Addr 0: read-only, returns `ID_VALUE`.
  - Addr 1: read-only 8-bit transaction counter. It increments in every EXEC, wraps 255→0, and resets to 0.
  - Addrs 2..2^ADDR_W−1: read/write storage, reset to 0.
- Read: `rdata` = register value. A read of addr 1 returns the counter value from before this transaction's increment.
- Write to a RW address: store `wdata`, and `rdata` echoes `wdata`.
- Write to addr 0 or 1: storage is unchanged, `rdata` = current value, and `err` is set.
- `err` clears on a read of addr 0. If the same EXEC both sets and clears it, set wins (this cannot happen through the register map, but the priority is fixed).
- `ena` falling mid-transaction: the transaction still completes normally.
- `rst` in any state: FSM returns to IDLE. `rdata`, `ack`, `err`, the counter and all RW registers are cleared. Synchroniser flops clear to 0, so a `strb` held high through reset is seen as a new rise after reset releases.

## Timing

- Reset values: `rdata`=0, `ack`=0, `busy`=0, `err`=0.
- If `strb`=1 is first sampled by `s1` at edge k:
  - `s2`=1 after edge k+1.
  - FSM enters EXEC at edge k+2, and `busy` rises then.
  - `ack`=1 and `rdata` are valid after edge k+3, a 3-cycle latency.
- If `strb` low is first sampled at edge m: `s2`=0 after m+1, and `ack`/`busy` drop after edge m+2.
- Minimum host strobe low time is 3 cycles. A shorter low pulse may be missed; such a pulse is a protocol violation and no behaviour is defined for it.
- One transaction at a time. No pipelining.

## Configuration

- `RESP_TIMEOUT_EN` defined:
  - An 8-bit counter clears on ACK entry and increments each cycle in ACK.
  - When it reaches `TIMEOUT` with `s2` still 1, clear `ack`, set `err`, and go to IDLE.
  - The still-high strobe does not retrigger, because a rise needs a fresh 0→1.
- `RESP_TIMEOUT_EN` undefined:
  - No timeout logic is present.
  - ACK is held indefinitely until `strb` falls.

## Test plan

- Reset: assert `rst` 2 cycles with `strb`=1 → `rdata`=0, `ack`=0, `busy`=0, `err`=0; after release, one transaction executes.
- Write then read: write 8'h3C to addr 5, then read addr 5 → `ack` rises exactly 3 edges after `strb` is sampled; the read returns 8'h3C; addr 1 then reads 8'h02.
- ID and error: read addr 0 → 8'hA5. Write 8'hFF to addr 0 → `err`=1 and `rdata`=8'hA5. Read addr 0 → `err`=0.
- Counter wrap: 256 transactions after reset, then read addr 1 → 8'h00 (the pre-increment value).
- Enable gating: `ena`=0 with a `strb` pulse → no `ack`, counter unchanged. Set `ena`=1 again with `strb` still high → still no `ack`. The next strobe pulse is served.
- Timeout:
  - With `RESP_TIMEOUT_EN`: hold `strb` high for 300 cycles → `ack` drops 255 cycles after ACK entry, `err`=1, and there is no retrigger.
  - Without the macro: the same stimulus leaves `ack` high for all 300 cycles.

Source files
------------

// File: rtl/pin_bus_responder.sv
// pin_bus_responder: four-phase pin-bus target with ID, transaction counter and RW registers; define RESP_TIMEOUT_EN to bound the time spent in ACK
module pin_bus_responder #(
  parameter int         ADDR_W   = 4,
  parameter logic [7:0] ID_VALUE = 8'hA5,
  parameter int         TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              strb,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
  state_t state, nxt;
  logic s1, s2, s3;
  logic l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [7:0] l_wdata;
  logic [7:0] cnt;
  logic [7:0] mem [2**ADDR_W];
  logic [7:0] cur;
  logic rise, ro, tmo, start;
  assign rise  = s2 & ~s3;
  assign start = state == IDLE && rise && ena;
  assign ro    = l_addr[ADDR_W-1:1] == '0;
  assign cur   = l_addr == '0 ? ID_VALUE : l_addr == ADDR_W'(1) ? cnt : mem[l_addr];
  assign busy  = state != IDLE;
`ifdef RESP_TIMEOUT_EN
  logic [7:0] tcnt;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  // cycles spent in ACK; zero on entry
  always_ff @(posedge clk)
    if (rst || state != ACK) tcnt <= '0;
    else tcnt <= tcnt + 8'd1;
  assign tmo = s2 && tcnt == TO_LAST;
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo = 1'b0;
`endif
  // next state: start on a fresh enabled rise, release ACK on strobe fall or timeout
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (start ? EXEC : IDLE) :
          state == EXEC ? ACK : ((!s2 || tmo) ? IDLE : ACK);
  end
  // synchroniser, state, command latch, register file and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state   <= IDLE;
      ack     <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
      cnt     <= '0;
      l_we    <= 1'b0;
      l_addr  <= '0;
      l_wdata <= '0;
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
    end else begin
      s1    <= strb;
      s2    <= s1;
      s3    <= s2;
      state <= nxt;
      ack   <= nxt == ACK;
      if (start) begin
        l_we    <= we;
        l_addr  <= addr;
        l_wdata <= wdata;
      end
      if (state == EXEC) begin
        cnt   <= cnt + 8'd1;
        rdata <= (l_we && !ro) ? l_wdata : cur;
        if (l_we && !ro) mem[l_addr] <= l_wdata;
        err   <= (l_we && ro) | (err & ~(!l_we && l_addr == '0));
      end else if (state == ACK && tmo) err <= 1'b1;
    end
  end
endmodule
